// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: byte width and default FIFO sizing.
package uart_rx_fifo_pkg;

    localparam int unsigned UART_DATA_W    = 8;
    localparam int unsigned FIFO_DEPTH     = 16;
    localparam int unsigned FIFO_AFULL_LVL = 12;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: show-ahead valid/ready output,
// fill level, almost-full and a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = UART_DATA_W,
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned AFULL_LVL = FIFO_AFULL_LVL
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              r_overflow;

    logic [PW-1:0]     w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // Status is derived only from the registered pointers.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees the slot, so a write into a full FIFO is still accepted that cycle.
    assign w_pop  = !w_empty && out_ready;
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // A new drop wins over a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    assign out_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid   = !w_empty;
    assign count       = w_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (w_count >= PW'(AFULL_LVL));
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFULL = 12;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       ovf_clr;

    int n_cmp;
    int n_fail;

    logic [7:0] m_q[$];
    logic       m_ovf;

    uart_rx_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic tick(input logic rst, input logic v, input logic [7:0] d,
                        input logic rdy, input logic clr);
        logic pop;
        logic drop;
        rst_n     = rst;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = (m_q.size() > 0) && rdy;
            drop = v && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (v && !drop) m_q.push_back(d);
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        n_cmp++;
        if (count !== 5'd0 || empty !== 1'b1 || out_valid !== 1'b0 ||
            out_data !== 8'h00 || overflow !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d emp=%b ov=%b od=%h ovf=%b full=%b af=%b want 0 1 0 00 0 0 0",
                     count, empty, out_valid, out_data, overflow, full, almost_full);
        end
        tick(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        n_cmp++;
        if (count !== 5'd1 || out_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL reset_release: got cnt=%0d od=%h want 1 3c", count, out_data);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_single();
        tick(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_byte: got ov=%b od=%h cnt=%0d want 1 a5 1", out_valid, out_data, count);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (empty !== 1'b1 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL single_pop: got emp=%b od=%h want 1 00", empty, out_data);
        end
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
            n_cmp++;
            if (count !== 5'(i + 1) || almost_full !== (i + 1 >= AFULL) || full !== (i + 1 == DEPTH)) begin
                n_fail++;
                $display("FAIL fill_level[%0d]: got cnt=%0d af=%b full=%b want %0d %b %b",
                         i, count, almost_full, full, i + 1, (i + 1 >= AFULL), (i + 1 == DEPTH));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (out_data !== 8'(i) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got od=%h ov=%b want %h 1", i, out_data, out_valid, 8'(i));
            end
            tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL drain_empty: got emp=%b cnt=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b1, 8'($urandom_range(0, 8'h54)), 1'b0, 1'b0);
        tick(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%b cnt=%0d want 1 16", overflow, count);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got %b want 0", overflow);
        end
        tick(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_beats_clr: got %b want 1", overflow);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (out_data !== m_q[0] || out_data === 8'h55) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got %h want %h", i, out_data, m_q[0]);
            end
            tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b1, 8'($urandom_range(0, 8'h76)), 1'b0, 1'b0);
        tick(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        n_cmp++;
        if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_push_pop: got cnt=%0d ovf=%b full=%b want 16 0 1", count, overflow, full);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (out_data !== m_q[0] || (i == DEPTH - 1 && out_data !== 8'h77)) begin
                n_fail++;
                $display("FAIL fpp_drain[%0d]: got %h want %h", i, out_data, (i == DEPTH - 1) ? 8'h77 : m_q[0]);
            end
            tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] got[$];
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) got.push_back(out_data);
            tick(1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
            n_cmp++;
            if (count > 5'd1) begin
                n_fail++;
                $display("FAIL stream_count[%0d]: got %0d want <=1", i, count);
            end
        end
        for (int i = 0; i < 4 && out_valid === 1'b1; i++) begin
            got.push_back(out_data);
            tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if (got.size() != 40) begin
            n_fail++;
            $display("FAIL stream_len: got %0d want 40", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 8'(i)) begin
                n_fail++;
                $display("FAIL stream_data[%0d]: got %h want %h", i, got[i], 8'(i));
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got emp=%b cnt=%0d ovf=%b od=%h want 1 0 0 00", empty, count, overflow, out_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6), 8'($urandom),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
            exp_d = (m_q.size() > 0) ? m_q[0] : 8'h00;
            n_cmp++;
            if (count !== 5'(m_q.size()) || empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH) ||
                almost_full !== (m_q.size() >= AFULL) || out_valid !== (m_q.size() != 0) ||
                out_data !== exp_d || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random[%0d]: got cnt=%0d od=%h ovf=%b af=%b want cnt=%0d od=%h ovf=%b af=%b",
                         i, count, out_data, overflow, almost_full, m_q.size(), exp_d, m_ovf, (m_q.size() >= AFULL));
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        n_cmp     = 0;
        n_fail    = 0;
        m_ovf     = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_order();
        test_overflow();
        test_full_push_pop();
        test_streaming();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
